corr_frame_sched: RTL and testbench
===================================

// Module: corr_frame_sched
// PURPOSE
// - Sequencer for the correlation datapath. Buffers one frame of N unsigned samples, then time-shares a single
//   multiply-accumulate unit across lags 0..LAGS-1, computing R[k] = sum_{n=k..N-1} x[n]*x[n-k].
// - Sits between the sample source and the correlation result consumer; both sides use a valid/ready handshake.
// PARAMETERS
// - DATA_W  8   sample width, unsigned
// - N       16  samples per frame; N>=2
// - LAGS    4   lags computed per frame; 1<=LAGS<=N
// - ACC_W   2*DATA_W+$clog2(N)   accumulator/result width (derived; do not override)
// - LAG_W   max(1,$clog2(LAGS))  lag index width (derived)
// PORTS
// - clk         in   1       rising-edge clock
// - rst         in   1       asynchronous, active-high reset
// - clear       in   1       synchronous abort; returns to IDLE and discards the frame
// - x_in        in   DATA_W  sample
// - x_valid     in   1       sample valid
// - x_ready     out  1       high only in IDLE/LOAD
// - y_out       out  ACC_W   R[y_lag]
// - y_lag       out  LAG_W   lag index of y_out
// - y_valid     out  1       result valid; held with y_out/y_lag stable until y_ready
// - y_ready     in   1       consumer accept
// - busy        out  1       high in every state except IDLE
// - frame_done  out  1       one-cycle pulse on acceptance of lag LAGS-1
// BEHAVIOUR
// - Reset: state=IDLE; all counters, accumulator, y_out, y_lag = 0; x_ready=1; y_valid, busy, frame_done = 0.
// - FSM: IDLE -> LOAD on the first accepted sample. LOAD -> MAC when sample N-1 is accepted (buffer writes
//   index 0..N-1 in order). MAC -> OUT after the last term of lag k. OUT -> MAC (k+1) on y_valid&y_ready with
//   k<LAGS-1; OUT -> IDLE on y_valid&y_ready with k==LAGS-1, pulsing frame_done in that same cycle.
// - MAC: lag k takes exactly N-k cycles, one product per cycle, n counting k..N-1. The accumulator is cleared
//   on MAC entry; y_valid rises in the cycle after the last product. Products and sums are unsigned and never
//   overflow at ACC_W.
// - x_ready=0 in MAC/OUT; input is stalled, never dropped. Frames are processed back-to-back, never overlapped.
// - y_valid=1 with y_ready=0: hold indefinitely; y_out and y_lag must not change.
// - clear: highest priority after rst; forces IDLE and zeroes the counters and y_valid in the next cycle, from
//   any state. A sample presented in the clear cycle is not accepted.
// - rst mid-frame: immediate return to the reset values listed above; the partial frame is lost.
// - Single-cycle worst-case frame time: N + sum_{k<LAGS}(N-k+1), plus any consumer stall.
// CONFIGURATION
// - `CORR_PEAK_EN defined: adds outputs peak_lag[LAG_W], peak_val[ACC_W] and peak_valid. These track the maximum
//   R[k] over k>=1 (ties -> lowest k). peak_valid pulses together with frame_done, and peak_lag/peak_val are
//   held until the next frame_done. With LAGS==1: peak_lag=0, peak_val=0. All three reset to 0.
// - Undefined: the ports and tracking logic are absent; all other behaviour is identical.
// STRUCTURE
// - corr_pkg: state enum (IDLE, LOAD, MAC, OUT), clog2-based width helper functions, ACC_W/LAG_W derivation.
// - Sub-module corr_sample_buf: N x DATA_W register file with one write port and two asynchronous read ports
//   (x[n], x[n-k]); no reset required on the storage. The FSM, counters, MAC and peak tracker stay in the top.
// TESTING
// - N=4,LAGS=3, samples 1,2,3,4, y_ready=1 -> R0=30, R1=20, R2=11 on lags 0,1,2; frame_done once; MAC phases of
//   4,3,2 cycles.
// - Same frame with y_ready held 0 for 5 cycles at lag 1 -> y_out=20 and y_lag=1 stable throughout; x_ready=0.
// - N=4,LAGS=3, samples 255x4 -> R0=260100, R1=195075, R2=130050, with no overflow (ACC_W=18).
// - clear asserted on the 3rd MAC cycle of lag 0 -> IDLE next cycle, y_valid never rises; a new frame 1,1,1,1
//   then gives R0=4, R1=3, R2=2.
// - rst pulsed during OUT -> all outputs at reset values asynchronously; x_ready=1 after release.
// - `CORR_PEAK_EN, N=4,LAGS=3, samples 1,0,1,0 -> R=2,0,1; peak_lag=2, peak_val=1, peak_valid coincides with
//   frame_done.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared types and width helpers for the frame-based correlation sequencer.
package corr_pkg;

  // Sequencer phases: wait for a frame, fill the buffer, run one lag, offer its result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    OUT  = 2'd3
  } state_e;

  // clog2 that never returns zero, so a single-entry range still gets a 1-bit index.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // Accumulator width: full product plus growth for N terms.
  function automatic int acc_w(input int data_w, input int n);
    return 2 * data_w + $clog2(n);
  endfunction

  // Lag index width.
  function automatic int lag_w(input int lags);
    return clog2_min1(lags);
  endfunction

endpackage

// File: rtl/corr_frame_sched_if.sv
// Sample-in / result-out handshake bundle for corr_frame_sched.
// CORR_PEAK_EN adds the peak_lag / peak_val / peak_valid signals.
interface corr_frame_sched_if #(
  parameter int DATA_W = 8,
  parameter int N      = 16,
  parameter int LAGS   = 4
);
  localparam int ACC_W = corr_pkg::acc_w(DATA_W, N);
  localparam int LAG_W = corr_pkg::lag_w(LAGS);

  logic              clear;
  logic [DATA_W-1:0] x_in;
  logic              x_valid;
  logic              x_ready;
  logic [ACC_W-1:0]  y_out;
  logic [LAG_W-1:0]  y_lag;
  logic              y_valid;
  logic              y_ready;
  logic              busy;
  logic              frame_done;
`ifdef CORR_PEAK_EN
  logic [LAG_W-1:0]  peak_lag;
  logic [ACC_W-1:0]  peak_val;
  logic              peak_valid;

  modport master (
    output clear, x_in, x_valid, y_ready,
    input  x_ready, y_out, y_lag, y_valid, busy, frame_done,
    input  peak_lag, peak_val, peak_valid
  );
  modport slave (
    input  clear, x_in, x_valid, y_ready,
    output x_ready, y_out, y_lag, y_valid, busy, frame_done,
    output peak_lag, peak_val, peak_valid
  );
`else
  modport master (
    output clear, x_in, x_valid, y_ready,
    input  x_ready, y_out, y_lag, y_valid, busy, frame_done
  );
  modport slave (
    input  clear, x_in, x_valid, y_ready,
    output x_ready, y_out, y_lag, y_valid, busy, frame_done
  );
`endif
endinterface

// File: rtl/corr_sample_buf.sv
// One-frame sample store: single write port, two combinational read ports
// feeding x[n] and x[n-k] to the multiplier. Storage is not reset.
module corr_sample_buf #(
  parameter int DATA_W = 8,
  parameter int N      = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem_r [N];

  // Write the accepted sample into its frame slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_r[raddr_a];
  assign rdata_b = mem_r[raddr_b];
endmodule

// File: rtl/corr_frame_sched.sv
// Frame correlation sequencer: buffers N samples, then computes R[k] for
// k = 0..LAGS-1 on one shared multiply-accumulate, one term per cycle.
// CORR_PEAK_EN adds a tracker for the largest R[k] with k >= 1.
module corr_frame_sched
  import corr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N      = 16,
  parameter int LAGS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  corr_frame_sched_if.slave bus
);
  localparam int ACC_W = acc_w(DATA_W, N);
  localparam int LAG_W = lag_w(LAGS);
  localparam int CNT_W = clog2_min1(N);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N - 1);
  localparam logic [LAG_W-1:0] K_LAST = LAG_W'(LAGS - 1);

  state_e              state_r, state_s;
  logic [CNT_W-1:0]    n_r;
  logic [LAG_W-1:0]    k_r;
  logic [ACC_W-1:0]    acc_r;
  logic [ACC_W-1:0]    y_out_r;
  logic [LAG_W-1:0]    y_lag_r;

  logic                x_ready_s, y_valid_s, busy_s;
  logic                x_acc_s, y_acc_s, last_lag_s, frame_done_s;
  logic [DATA_W-1:0]   xa_s, xb_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [ACC_W-1:0]    acc_sum_s;

  // A sample or result is only taken when clear is not overriding the cycle.
  assign x_acc_s      = bus.x_valid & x_ready_s & ~bus.clear;
  assign y_acc_s      = y_valid_s & bus.y_ready & ~bus.clear;
  assign last_lag_s   = (k_r == K_LAST);
  assign frame_done_s = y_acc_s & last_lag_s;

  corr_sample_buf #(
    .DATA_W (DATA_W),
    .N      (N),
    .AW     (CNT_W)
  ) u_buf (
    .clk     (clk),
    .we      (x_acc_s),
    .waddr   (n_r),
    .wdata   (bus.x_in),
    .raddr_a (n_r),
    .rdata_a (xa_s),
    .raddr_b (n_r - CNT_W'(k_r)),
    .rdata_b (xb_s)
  );

  assign prod_s    = xa_s * xb_s;
  assign acc_sum_s = acc_r + ACC_W'(prod_s);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; clear wins over every transition.
  always_comb begin
    state_s = state_r;
    if (bus.clear) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (x_acc_s) state_s = LOAD;
          else         state_s = IDLE;
        end
        LOAD: begin
          if (x_acc_s && (n_r == N_LAST)) state_s = MAC;
          else                            state_s = LOAD;
        end
        MAC: begin
          if (n_r == N_LAST) state_s = OUT;
          else               state_s = MAC;
        end
        OUT: begin
          if (y_acc_s) begin
            if (last_lag_s) state_s = IDLE;
            else            state_s = MAC;
          end else begin
            state_s = OUT;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    x_ready_s = 1'b0;
    y_valid_s = 1'b0;
    busy_s    = 1'b1;
    case (state_r)
      IDLE: begin
        x_ready_s = 1'b1;
        busy_s    = 1'b0;
      end
      LOAD:    x_ready_s = 1'b1;
      MAC:     busy_s    = 1'b1;
      OUT:     y_valid_s = 1'b1;
      default: busy_s    = 1'b0;
    endcase
  end

  // Counters, accumulator and the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r     <= {CNT_W{1'b0}};
      k_r     <= {LAG_W{1'b0}};
      acc_r   <= {ACC_W{1'b0}};
      y_out_r <= {ACC_W{1'b0}};
      y_lag_r <= {LAG_W{1'b0}};
    end else if (bus.clear) begin
      n_r   <= {CNT_W{1'b0}};
      k_r   <= {LAG_W{1'b0}};
      acc_r <= {ACC_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (x_acc_s) n_r <= CNT_W'(1);
        end
        LOAD: begin
          if (x_acc_s) begin
            if (n_r == N_LAST) begin
              // Buffer full: lag 0 starts at n = 0 with a clean accumulator.
              n_r   <= {CNT_W{1'b0}};
              k_r   <= {LAG_W{1'b0}};
              acc_r <= {ACC_W{1'b0}};
            end else begin
              n_r <= n_r + CNT_W'(1);
            end
          end
        end
        MAC: begin
          acc_r <= acc_sum_s;
          if (n_r == N_LAST) begin
            y_out_r <= acc_sum_s;
            y_lag_r <= k_r;
          end else begin
            n_r <= n_r + CNT_W'(1);
          end
        end
        OUT: begin
          if (y_acc_s) begin
            if (last_lag_s) begin
              n_r <= {CNT_W{1'b0}};
              k_r <= {LAG_W{1'b0}};
            end else begin
              // Next lag starts its sum at n = k+1.
              k_r   <= k_r + LAG_W'(1);
              n_r   <= CNT_W'(k_r) + CNT_W'(1);
              acc_r <= {ACC_W{1'b0}};
            end
          end
        end
        default: n_r <= {CNT_W{1'b0}};
      endcase
    end
  end

  assign bus.x_ready    = x_ready_s;
  assign bus.y_valid    = y_valid_s;
  assign bus.busy       = busy_s;
  assign bus.frame_done = frame_done_s;
  assign bus.y_out      = y_out_r;
  assign bus.y_lag      = y_lag_r;

`ifdef CORR_PEAK_EN
  logic [ACC_W-1:0] run_val_r, peak_val_r, cand_val_s, fin_val_s;
  logic [LAG_W-1:0] run_lag_r, peak_lag_r, cand_lag_s, fin_lag_s;

  // Running maximum including the result now on offer; lag 1 seeds it, ties keep the lower lag.
  always_comb begin
    if (k_r == LAG_W'(1'b1)) begin
      cand_val_s = y_out_r;
      cand_lag_s = k_r;
    end else if (y_out_r > run_val_r) begin
      cand_val_s = y_out_r;
      cand_lag_s = k_r;
    end else begin
      cand_val_s = run_val_r;
      cand_lag_s = run_lag_r;
    end
    if (LAGS == 1) begin
      fin_val_s = {ACC_W{1'b0}};
      fin_lag_s = {LAG_W{1'b0}};
    end else begin
      fin_val_s = cand_val_s;
      fin_lag_s = cand_lag_s;
    end
  end

  // Update the running maximum per accepted lag and latch the frame's peak at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_val_r  <= {ACC_W{1'b0}};
      run_lag_r  <= {LAG_W{1'b0}};
      peak_val_r <= {ACC_W{1'b0}};
      peak_lag_r <= {LAG_W{1'b0}};
    end else if (bus.clear) begin
      run_val_r <= {ACC_W{1'b0}};
      run_lag_r <= {LAG_W{1'b0}};
    end else begin
      if (y_acc_s && (k_r != {LAG_W{1'b0}})) begin
        run_val_r <= cand_val_s;
        run_lag_r <= cand_lag_s;
      end
      if (frame_done_s) begin
        peak_val_r <= fin_val_s;
        peak_lag_r <= fin_lag_s;
      end
    end
  end

  // The new peak is visible in the same cycle as its frame_done pulse.
  assign bus.peak_valid = frame_done_s;
  assign bus.peak_val   = frame_done_s ? fin_val_s : peak_val_r;
  assign bus.peak_lag   = frame_done_s ? fin_lag_s : peak_lag_r;
`endif

endmodule

// File: tb/tb_corr_frame_sched.sv
// Directed bench for corr_frame_sched with N=4, LAGS=3, DATA_W=8.
module tb_corr_frame_sched;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int NL = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  corr_frame_sched_if #(.DATA_W(DW), .N(NS), .LAGS(NL)) bus ();

  corr_frame_sched #(.DATA_W(DW), .N(NS), .LAGS(NL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    logic [7:0] s [4];
    s = '{a, b, c, d};
    for (int i = 0; i < NS; i++) begin
      bus.x_in    = s[i];
      bus.x_valid = 1'b1;
      #1;
      chk("x_ready_load", 32'(bus.x_ready), 32'd1);
      tick();
    end
    bus.x_valid = 1'b0;
    bus.x_in    = 8'd0;
  endtask

  task automatic run_lags(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                          input int stall_lag, input logic [31:0] pk_lag, input logic [31:0] pk_val);
    logic [31:0] er [3];
    int c;
    er = '{r0, r1, r2};
    for (int k = 0; k < NL; k++) begin
      bus.y_ready = (k == stall_lag) ? 1'b0 : 1'b1;
      c = 0;
      while (bus.y_valid !== 1'b1 && c < 20) begin
        tick();
        c++;
      end
      chk("mac_cycles", 32'(c), 32'(NS - k));
      chk("y_out", 32'(bus.y_out), er[k]);
      chk("y_lag", 32'(bus.y_lag), 32'(k));
      chk("x_ready_out", 32'(bus.x_ready), 32'd0);
      if (k == stall_lag) begin
        repeat (5) begin
          tick();
          chk("stall_y_out", 32'(bus.y_out), er[k]);
          chk("stall_y_lag", 32'(bus.y_lag), 32'(k));
          chk("stall_y_valid", 32'(bus.y_valid), 32'd1);
          chk("stall_x_ready", 32'(bus.x_ready), 32'd0);
        end
        bus.y_ready = 1'b1;
        #1;
      end
      chk("frame_done", 32'(bus.frame_done), 32'(k == NL - 1));
`ifdef CORR_PEAK_EN
      chk("peak_valid", 32'(bus.peak_valid), 32'(k == NL - 1));
      if (k == NL - 1) begin
        chk("peak_lag", 32'(bus.peak_lag), pk_lag);
        chk("peak_val", 32'(bus.peak_val), pk_val);
      end
`endif
      tick();
    end
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_x_ready", 32'(bus.x_ready), 32'd1);
    chk("end_frame_done", 32'(bus.frame_done), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_x_ready"}, 32'(bus.x_ready), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_y_valid"}, 32'(bus.y_valid), 32'd0);
    chk({tag, "_y_out"}, 32'(bus.y_out), 32'd0);
    chk({tag, "_y_lag"}, 32'(bus.y_lag), 32'd0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
`ifdef CORR_PEAK_EN
    chk({tag, "_peak_valid"}, 32'(bus.peak_valid), 32'd0);
    chk({tag, "_peak_val"}, 32'(bus.peak_val), 32'd0);
    chk({tag, "_peak_lag"}, 32'(bus.peak_lag), 32'd0);
`endif
  endtask

  initial begin
    int c;
    rst         = 1'b1;
    bus.clear   = 1'b0;
    bus.x_in    = 8'd0;
    bus.x_valid = 1'b0;
    bus.y_ready = 1'b1;
    #12;
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic frame 1,2,3,4.
    load(8'd1, 8'd2, 8'd3, 8'd4);
    run_lags(32'd30, 32'd20, 32'd11, -1, 32'd1, 32'd20);

    // Same frame, consumer stalls for 5 cycles on lag 1.
    load(8'd1, 8'd2, 8'd3, 8'd4);
    run_lags(32'd30, 32'd20, 32'd11, 1, 32'd1, 32'd20);

    // Full-scale samples.
    load(8'd255, 8'd255, 8'd255, 8'd255);
    run_lags(32'd260100, 32'd195075, 32'd130050, -1, 32'd1, 32'd195075);

    // Clear on the third MAC cycle of lag 0, with a sample presented.
    load(8'd1, 8'd2, 8'd3, 8'd4);
    tick();
    tick();
    bus.clear   = 1'b1;
    bus.x_valid = 1'b1;
    bus.x_in    = 8'd9;
    tick();
    bus.clear   = 1'b0;
    bus.x_valid = 1'b0;
    bus.x_in    = 8'd0;
    chk("clear_busy", 32'(bus.busy), 32'd0);
    chk("clear_x_ready", 32'(bus.x_ready), 32'd1);
    chk("clear_y_valid", 32'(bus.y_valid), 32'd0);
    repeat (6) begin
      tick();
      chk("clear_no_y_valid", 32'(bus.y_valid), 32'd0);
    end
    load(8'd1, 8'd1, 8'd1, 8'd1);
    run_lags(32'd4, 32'd3, 32'd2, -1, 32'd1, 32'd3);

    // Reset while a result is held in OUT.
    load(8'd1, 8'd2, 8'd3, 8'd4);
    bus.y_ready = 1'b0;
    c = 0;
    while (bus.y_valid !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    chk("pre_rst_y_valid", 32'(bus.y_valid), 32'd1);
    chk("pre_rst_y_out", 32'(bus.y_out), 32'd30);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    rst         = 1'b0;
    bus.y_ready = 1'b1;
    tick();
    chk("post_rst_x_ready", 32'(bus.x_ready), 32'd1);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    // Sparse frame 1,0,1,0: R = 2,0,1, peak at lag 2.
    load(8'd1, 8'd0, 8'd1, 8'd0);
    run_lags(32'd2, 32'd0, 32'd1, -1, 32'd2, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
